// File: rtl/alu4_rr_sequencer.sv
// Round-robin sequencer sharing one 4-bit ALU between two requesters.
// One operation in flight: accept -> exec -> respond, operands and result registered.
module alu4_rr_sequencer #(
   parameter int PRIO_INIT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic [2:0] req0_sel,
   output logic       rsp0_valid,
   output logic [4:0] rsp0_data,
   input  logic       rsp0_ready,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   input  logic [2:0] req1_sel,
   output logic       rsp1_valid,
   output logic [4:0] rsp1_data,
   input  logic       rsp1_ready,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_sel,
   input  logic [4:0] alu_out,
   output logic       busy,
   output logic       owner
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t     state_q, state_d;
   logic       ptr_q, ptr_d;
   logic       owner_q, owner_d;
   logic [3:0] opa_q, opa_d;
   logic [3:0] opb_q, opb_d;
   logic [2:0] sel_q, sel_d;
   logic [4:0] res_q, res_d;
   logic       winner;
   logic       any_valid;
   logic       rsp_ack;

   // Pointer only breaks ties; a lone requester always wins.
   assign any_valid = req0_valid | req1_valid;
   assign winner    = (req0_valid & req1_valid) ? ptr_q : req1_valid;
   assign rsp_ack   = owner_q ? rsp1_ready : rsp0_ready;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      sel_d      = sel_q;
      res_d      = res_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_valid) begin
               req0_ready = ~winner;
               req1_ready = winner;
               opa_d      = winner ? req1_a : req0_a;
               opb_d      = winner ? req1_b : req0_b;
               sel_d      = winner ? req1_sel : req0_sel;
               owner_d    = winner;
               ptr_d      = ~winner;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            res_d   = alu_out;
            state_d = RESP;
         end
         RESP: begin
            rsp0_valid = ~owner_q;
            rsp1_valid = owner_q;
            if (rsp_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= PRIO_INIT[0];
         owner_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         sel_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sel_q   <= sel_d;
         res_q   <= res_d;
      end
   end

   assign alu_a     = opa_q;
   assign alu_b     = opb_q;
   assign alu_sel   = sel_q;
   assign rsp0_data = res_q;
   assign rsp1_data = res_q;
   assign busy      = (state_q != IDLE);
   assign owner     = owner_q;

endmodule

// File: tb/tb_alu4_rr_sequencer.sv
// Bench for alu4_rr_sequencer: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_alu4_rr_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready;
   logic [3:0] req0_a, req0_b;
   logic [2:0] req0_sel;
   logic [4:0] rsp0_data;
   logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready;
   logic [3:0] req1_a, req1_b;
   logic [2:0] req1_sel;
   logic [4:0] rsp1_data;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_sel;
   logic [4:0] alu_out;
   logic       busy, owner;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   alu4_rr_sequencer #(.PRIO_INIT(0)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
      .busy(busy), .owner(owner)
   );

   // Stand-in ALU: add, sub, and, or, xor, not, shl, shr with 5-bit result.
   function automatic logic [4:0] alu_f(logic [3:0] a, logic [3:0] b,
                                        logic [2:0] s);
      case (s)
         3'd0: return {1'b0, a} + {1'b0, b};
         3'd1: return {1'b0, a} - {1'b0, b};
         3'd2: return {1'b0, a & b};
         3'd3: return {1'b0, a | b};
         3'd4: return {1'b0, a ^ b};
         3'd5: return {1'b0, ~a};
         3'd6: return {a, 1'b0};
         default: return {2'b00, a[3:1]};
      endcase
   endfunction

   assign alu_out = alu_f(alu_a, alu_b, alu_sel);

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
      rsp0_ready = 0; rsp1_ready = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      rst = 1'b0;
   endtask

   typedef struct {
      logic       who;
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] sel;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[7];

   // Reference model state: one transaction, aged by cycles since accept.
   logic       m_in;
   int         m_age;
   logic       m_own;
   logic       m_ptr;
   logic [4:0] m_res;

   initial begin
      logic win, any, acc0, acc1;
      logic e_rd0, e_rd1, e_rv0, e_rv1;
      logic [4:0] held;

      tbl[0] = '{1'b0, 4'h3, 4'h5, 3'd0, 5'b01000};
      tbl[1] = '{1'b1, 4'h3, 4'h5, 3'd1, 5'b11110};
      tbl[2] = '{1'b0, 4'hF, 4'h3, 3'd2, 5'b00011};
      tbl[3] = '{1'b1, 4'h8, 4'h1, 3'd3, 5'b01001};
      tbl[4] = '{1'b0, 4'hF, 4'hF, 3'd0, 5'b11110};
      tbl[5] = '{1'b1, 4'h0, 4'h1, 3'd1, 5'b11111};
      tbl[6] = '{1'b0, 4'h5, 4'hA, 3'd4, 5'b01111};

      do_reset();
      sample();
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_sel", alu_sel, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_rsp0_data", rsp0_data, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);

      step();
      foreach (tbl[i]) begin
         rsp0_ready = 1; rsp1_ready = 1;
         if (tbl[i].who) begin
            req1_valid = 1; req1_a = tbl[i].a;
            req1_b = tbl[i].b; req1_sel = tbl[i].sel;
         end else begin
            req0_valid = 1; req0_a = tbl[i].a;
            req0_b = tbl[i].b; req0_sel = tbl[i].sel;
         end
         sample();
         chk("tbl_req0_ready", req0_ready, !tbl[i].who);
         chk("tbl_req1_ready", req1_ready, tbl[i].who);
         chk("tbl_busy_idle", busy, 0);
         step();
         req0_valid = 0; req1_valid = 0;
         sample();
         chk("tbl_busy_exec", busy, 1);
         chk("tbl_alu_a", alu_a, tbl[i].a);
         chk("tbl_alu_b", alu_b, tbl[i].b);
         chk("tbl_alu_sel", alu_sel, tbl[i].sel);
         chk("tbl_owner", owner, tbl[i].who);
         chk("tbl_ready_exec", {req0_ready, req1_ready}, 0);
         step();
         sample();
         chk("tbl_rsp0_valid", rsp0_valid, !tbl[i].who);
         chk("tbl_rsp1_valid", rsp1_valid, tbl[i].who);
         chk("tbl_rsp_data", tbl[i].who ? rsp1_data : rsp0_data, tbl[i].exp);
         step();
         sample();
         chk("tbl_busy_after", busy, 0);
         chk("tbl_rsp_after", {rsp0_valid, rsp1_valid}, 0);
         step();
      end

      // Contention: both requesters valid continuously.
      do_reset();
      req0_valid = 1; req0_a = 4'hF; req0_b = 4'h3; req0_sel = 3'd2;
      req1_valid = 1; req1_a = 4'h8; req1_b = 4'h1; req1_sel = 3'd3;
      rsp0_ready = 1; rsp1_ready = 1;
      for (int k = 0; k < 4; k++) begin
         logic e;
         e = k[0];
         sample();
         chk("rr_req0_ready", req0_ready, !e);
         chk("rr_req1_ready", req1_ready, e);
         step();
         sample();
         chk("rr_owner", owner, e);
         step();
         sample();
         chk("rr_rsp0_valid", rsp0_valid, !e);
         chk("rr_rsp1_valid", rsp1_valid, e);
         chk("rr_data", e ? rsp1_data : rsp0_data, e ? 5'b01001 : 5'b00011);
         step();
      end

      // Backpressure on requester 0 while requester 1 waits.
      do_reset();
      req0_valid = 1; req0_a = 4'h3; req0_b = 4'h5; req0_sel = 3'd0;
      req1_valid = 1; req1_a = 4'h8; req1_b = 4'h1; req1_sel = 3'd3;
      rsp0_ready = 0; rsp1_ready = 1;
      sample();
      chk("bp_req0_ready", req0_ready, 1);
      step();
      req0_valid = 0;
      step();
      for (int k = 0; k < 5; k++) begin
         sample();
         chk("bp_rsp0_valid", rsp0_valid, 1);
         chk("bp_rsp0_data", rsp0_data, 5'b01000);
         chk("bp_busy", busy, 1);
         chk("bp_req1_ready", req1_ready, 0);
         step();
      end
      rsp0_ready = 1;
      sample();
      chk("bp_rsp0_release", rsp0_valid, 1);
      step();
      sample();
      chk("bp_idle_busy", busy, 0);
      chk("bp_idle_rsp0", rsp0_valid, 0);
      chk("bp_req1_grant", req1_ready, 1);
      step();
      req1_valid = 0;
      step();
      sample();
      chk("bp_rsp1_valid", rsp1_valid, 1);
      chk("bp_rsp1_data", rsp1_data, 5'b01001);
      step();

      // Reset during EXEC discards the operation.
      do_reset();
      req1_valid = 1; req1_a = 4'h3; req1_b = 4'h5; req1_sel = 3'd1;
      rsp0_ready = 1; rsp1_ready = 1;
      sample();
      chk("mr_req1_ready", req1_ready, 1);
      step();
      req1_valid = 0;
      sample();
      chk("mr_exec_busy", busy, 1);
      chk("mr_exec_alu_a", alu_a, 3);
      rst = 1;
      step();
      rst = 0;
      sample();
      chk("mr_busy", busy, 0);
      chk("mr_owner", owner, 0);
      chk("mr_alu", {alu_a, alu_sel}, 0);
      chk("mr_alu_b", alu_b, 0);
      chk("mr_rsp1_data", rsp1_data, 0);
      chk("mr_readies", {req0_ready, req1_ready}, 0);
      for (int k = 0; k < 3; k++) begin
         chk("mr_no_rsp", {rsp0_valid, rsp1_valid}, 0);
         step();
         sample();
      end
      req0_valid = 1; req1_valid = 1;
      #1;
      chk("mr_prio_req0", req0_ready, 1);
      chk("mr_prio_req1", req1_ready, 0);
      step();

      // Idle with pointer at 0, lone req1 still wins.
      do_reset();
      rsp1_ready = 1;
      for (int k = 0; k < 10; k++) begin
         sample();
         chk("idle_busy", busy, 0);
         chk("idle_readies", {req0_ready, req1_ready}, 0);
         step();
      end
      req1_valid = 1; req1_a = 4'h2; req1_b = 4'h2; req1_sel = 3'd0;
      sample();
      chk("idle_req1_ready", req1_ready, 1);
      chk("idle_req0_ready", req0_ready, 0);
      step();
      req1_valid = 0;
      step();
      sample();
      chk("idle_rsp1_data", rsp1_data, 5'b00100);
      step();
      for (int k = 0; k < 10; k++) step();
      req0_valid = 1; req1_valid = 1;
      sample();
      chk("idle_ptr_req0", req0_ready, 1);
      step();

      // Randomized traffic against the transaction model.
      do_reset();
      m_in = 0; m_age = 0; m_own = 0; m_ptr = 0; m_res = 0;
      acc0 = 0; acc1 = 0;
      for (int c = 0; c < 1500; c++) begin
         if (acc0) req0_valid = 0;
         if (acc1) req1_valid = 0;
         if (!req0_valid && $urandom_range(2) == 0) begin
            req0_valid = 1; req0_a = 4'($urandom);
            req0_b = 4'($urandom); req0_sel = 3'($urandom);
         end
         if (!req1_valid && $urandom_range(2) == 0) begin
            req1_valid = 1; req1_a = 4'($urandom);
            req1_b = 4'($urandom); req1_sel = 3'($urandom);
         end
         rsp0_ready = ($urandom_range(3) != 0);
         rsp1_ready = ($urandom_range(3) != 0);
         sample();
         any = req0_valid | req1_valid;
         win = (req0_valid & req1_valid) ? m_ptr : req1_valid;
         e_rd0 = !m_in && any && !win;
         e_rd1 = !m_in && any && win;
         e_rv0 = m_in && m_age == 2 && !m_own;
         e_rv1 = m_in && m_age == 2 && m_own;
         chk("rnd_req0_ready", req0_ready, e_rd0);
         chk("rnd_req1_ready", req1_ready, e_rd1);
         chk("rnd_rsp0_valid", rsp0_valid, e_rv0);
         chk("rnd_rsp1_valid", rsp1_valid, e_rv1);
         chk("rnd_busy", busy, m_in);
         if (e_rv0) chk("rnd_rsp0_data", rsp0_data, m_res);
         if (e_rv1) chk("rnd_rsp1_data", rsp1_data, m_res);
         acc0 = e_rd0;
         acc1 = e_rd1;
         if (!m_in && any) begin
            m_in = 1; m_age = 1; m_own = win; m_ptr = !win;
            m_res = win ? alu_f(req1_a, req1_b, req1_sel)
                        : alu_f(req0_a, req0_b, req0_sel);
         end else if (m_in && m_age == 1) begin
            m_age = 2;
         end else if (m_in && (m_own ? rsp1_ready : rsp0_ready)) begin
            m_in = 0;
         end
         step();
      end
      held = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu4_rr_sequencer.md
Name: alu4_rr_sequencer

Overview:
- Shares one combinational 4-bit ALU (`alu4`: 4-bit A/B, 3-bit select, 5-bit result) between two requesters.
- Round-robin arbitration, one operation in flight at a time.
- Per-requester valid/ready request and response channels.
- Operands are registered before the ALU is driven; the result is registered and held until the owning requester accepts it.

Parameters:
- PRIO_INIT, 0: requester (0 or 1) that has priority after reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid
- req0_a  in  4  operand A, requester 0
- req0_b  in  4  operand B, requester 0
- req0_sel  in  3  ALU select, requester 0
- rsp0_valid  out  1  result for requester 0 available
- rsp0_data  out  5  result for requester 0
- rsp0_ready  in  1  requester 0 accepts the result
- req1_valid, req1_ready, req1_a, req1_b, req1_sel, rsp1_valid, rsp1_data, rsp1_ready: same as requester 0, for requester 1
- alu_a  out  4  to ALU A
- alu_b  out  4  to ALU B
- alu_sel  out  3  to ALU select
- alu_out  in  5  from ALU result (combinational, same cycle)
- busy  out  1  high in EXEC or RESP
- owner  out  1  index of requester owning the current/last operation

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE, priority pointer=PRIO_INIT.
  - Operand registers, result register, owner, alu_a/alu_b/alu_sel all 0.
  - All ready/valid outputs 0.
  - Reset mid-operation silently discards the in-flight operation; no response is issued.
- State machine, 3 states:
  - IDLE:
    - winner = the only valid requester; if both valid, the requester named by the pointer.
    - reqN_ready = 1 for the winner only, combinational in IDLE; 0 in all other states.
    - On handshake: latch a/b/sel into operand registers; owner<=winner; pointer<=~winner (loser gets priority next); go to EXEC.
    - No valid requester: stay in IDLE; pointer unchanged.
  - EXEC, one cycle:
    - alu_a/alu_b/alu_sel driven from operand registers (these outputs come from registers in every state, so no glitch into the ALU).
    - At the end of the cycle, alu_out is captured into the result register; go to RESP.
  - RESP:
    - rsp<owner>_valid=1 and rsp<owner>_data=result register; the other rsp_valid=0.
    - Data is stable until the handshake.
    - rsp<owner>_ready=1 → go to IDLE, deassert valid next cycle.
    - The other requester's rsp_ready is ignored.
- rspN_data holds the last result for that requester when not valid. The value is don't-care for checking; the implementation holds the register.
- Latency: request handshake at cycle N, EXEC at N+1, rsp_valid high at N+2.
  - Minimum 3 cycles per operation (accept, exec, respond-with-ready-high).
  - The next accept comes no earlier than the cycle after the response handshake.
- Requesters must hold reqN_valid and operands stable until ready; the block does not buffer unaccepted requests.
- ALU results are passed through unmodified at 5 bits (carry/borrow bit included). The block does no arithmetic itself.
- Simultaneous events:
  - A request and a response for the same requester in the same cycle: the response completes; the request is considered in the next IDLE cycle.
  - busy=1 exactly when state≠IDLE.

Test Plan:
- Single add: reset, req0 A=3 B=5 sel=000, rsp0_ready=1 → req0_ready at cycle 0, alu_a=3/alu_b=5 at cycle 1, rsp0_valid with data 5'b01000 at cycle 2, idle at cycle 3.
- Subtract wrap: req1 A=3 B=5 sel=001 → rsp1_data=5'b11110; rsp0_valid stays 0 throughout.
- Contention / round-robin: PRIO_INIT=0, both valid continuously (req0 sel=010 A=F B=3, req1 sel=011 A=8 B=1) → grants alternate 0,1,0,1; results 5'b00011 and 5'b01001 go to the correct channels.
- Backpressure: rsp0_ready held 0 for 5 cycles after rsp0_valid → data constant, busy=1, req1_ready stays 0; release → IDLE the next cycle, then req1 is granted.
- Reset mid-op: assert rst during EXEC → next cycle all outputs 0, no rsp_valid pulse; with both valid afterwards, the first grant goes to the PRIO_INIT requester.
- Idle/no-op: no requests for 10 cycles → busy=0, all readies 0, pointer unchanged, then a single req1 is granted even when the pointer=0.
